// File: rtl/load_store_unit.sv
// Memory stage of the MinCPU RV32I core: one outstanding load/store over a req/ack bus.
// Optional macro LSU_TIMEOUT_EN adds a bus-timeout access fault after TIMEOUT_CYCLES REQ cycles.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_is_load,
  input  logic                  ex_is_store,
  input  logic [2:0]            ex_funct3,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic [4:0]            ex_rd,
  input  logic                  flush,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  done,
  output logic                  exc_valid,
  output logic [3:0]            exc_cause,
  output logic [ADDR_WIDTH-1:0] exc_addr,
  output logic                  busy
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                  r_state, w_state_next;
  logic                    r_is_load;
  logic [2:0]              r_funct3;
  logic [1:0]              r_off;
  logic [4:0]              r_rd;
  logic                    r_flushed;
  logic                    w_accept, w_illegal, w_misalign, w_discard, w_timeout;
  logic [3:0]              w_cause, w_be;
  logic [DATA_WIDTH-1:0]   w_wdata, w_lane, w_load_data;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  assign w_timeout = (r_state == S_REQ) & ~mem_ack & (r_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign ex_ready  = (r_state == S_IDLE) & ~rst;
  assign busy      = (r_state == S_REQ);
  assign w_accept  = ex_valid & (r_state == S_IDLE) & (ex_is_load | ex_is_store);
  assign w_discard = r_flushed | flush;

  assign w_illegal = (ex_is_load & ex_is_store)
                   | (ex_is_load & ((ex_funct3 == 3'd3) | (ex_funct3 == 3'd6) | (ex_funct3 == 3'd7)))
                   | (ex_is_store & (ex_funct3 > 3'd2));
  assign w_misalign = ~w_illegal & (((ex_funct3[1:0] == 2'b01) & ex_addr[0])
                                  | ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00)));
  assign w_cause = w_illegal ? 4'd2 : (ex_is_load ? 4'd4 : 4'd6);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_store_data;
    if (ex_is_store) begin
      case (ex_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << ex_addr[1:0];
          w_wdata = {4{ex_store_data[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << ex_addr[1:0];
          w_wdata = {2{ex_store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign w_lane = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_data = w_lane;
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'd1:    w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'd4:    w_load_data = {24'd0, w_lane[7:0]};
      3'd5:    w_load_data = {16'd0, w_lane[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept & ~w_illegal & ~w_misalign) w_state_next = S_REQ;
      S_REQ:   if (mem_ack | w_timeout) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      done      <= 1'b0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_addr  <= '0;
      r_is_load <= 1'b0;
      r_funct3  <= '0;
      r_off     <= '0;
      r_rd      <= '0;
      r_flushed <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_cnt     <= '0;
      r_addr    <= '0;
`endif
    end else begin
      wb_valid  <= 1'b0;
      done      <= 1'b0;
      exc_valid <= 1'b0;
      if (w_accept) begin
        if (w_illegal | w_misalign) begin
          done      <= 1'b1;
          exc_valid <= ~flush;
          exc_cause <= w_cause;
          exc_addr  <= ex_addr;
        end else begin
          mem_req   <= 1'b1;
          mem_we    <= ex_is_store;
          mem_addr  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata <= w_wdata;
          mem_be    <= w_be;
          r_is_load <= ex_is_load;
          r_funct3  <= ex_funct3;
          r_off     <= ex_addr[1:0];
          r_rd      <= ex_rd;
          r_flushed <= flush;
`ifdef LSU_TIMEOUT_EN
          r_cnt     <= '0;
          r_addr    <= ex_addr;
`endif
        end
      end else if (r_state == S_REQ) begin
        // a flush only marks the op; the bus cycle is never withdrawn
        if (flush) r_flushed <= 1'b1;
        if (mem_ack) begin
          mem_req <= 1'b0;
          done    <= 1'b1;
          if (r_is_load & ~w_discard & (r_rd != 5'd0)) begin
            wb_valid <= 1'b1;
            wb_rd    <= r_rd;
            wb_data  <= w_load_data;
          end
        end else if (w_timeout) begin
          mem_req   <= 1'b0;
          done      <= 1'b1;
          exc_valid <= ~w_discard;
          exc_cause <= r_is_load ? 4'd5 : 4'd7;
`ifdef LSU_TIMEOUT_EN
          exc_addr  <= r_addr;
`endif
        end
`ifdef LSU_TIMEOUT_EN
        else begin
          r_cnt <= r_cnt + 8'd1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random ops vs a reference model,
// and hand-written reset / back-to-back / idle-ack / timeout sequences.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_ready, ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0, ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        flush = 1'b0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;
  logic        wb_valid, done, exc_valid, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [3:0]  exc_cause;

  load_store_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
`ifdef LSU_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  // flush_cyc: -1 none, 0 with the accept, k>=1 during REQ cycle k (0-based index k-1)
  typedef struct {
    bit ld, st; bit [2:0] f3; bit [31:0] addr, data, rdata; bit [4:0] rd;
    int ack_dly; int flush_cyc;
    bit e_req, e_we; bit [3:0] e_be; bit [31:0] e_wdata;
    bit e_wb; bit [31:0] e_wbdata; bit e_exc; bit [3:0] e_cause;
  } vec_t;

  int errors = 0, checks = 0;
  int p_wb, p_done, p_exc, req_cycles;
  logic [31:0] c_wbdata, c_excaddr;
  logic [4:0]  c_wbrd;
  logic [3:0]  c_cause;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit ld, bit st, bit [2:0] f3, bit [31:0] addr, bit [31:0] data,
                              bit [31:0] rdata, bit [4:0] rd, int ack, int fl,
                              bit e_req, bit e_we, bit [3:0] e_be, bit [31:0] e_wdata,
                              bit e_wb, bit [31:0] e_wbdata, bit e_exc, bit [3:0] e_cause);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.data = data; v.rdata = rdata; v.rd = rd;
    v.ack_dly = ack; v.flush_cyc = fl;
    v.e_req = e_req; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_wb = e_wb; v.e_wbdata = e_wbdata; v.e_exc = e_exc; v.e_cause = e_cause;
    return v;
  endfunction

  // Reference model: derived from access size and lane offset arithmetic.
  function automatic vec_t model(input vec_t v);
    int nb, off, last;
    bit illegal, disc;
    longint x;
    v.e_req = 0; v.e_we = 0; v.e_be = 0; v.e_wdata = 0; v.e_wb = 0; v.e_wbdata = 0;
    v.e_exc = 0; v.e_cause = 0;
    off = int'(v.addr % 4);
    nb = (v.f3 % 4 == 0) ? 1 : (v.f3 % 4 == 1) ? 2 : 4;
    illegal = (v.ld && v.st) || (v.ld && !(v.f3 inside {0, 1, 2, 4, 5})) || (v.st && v.f3 > 2);
    if (illegal) begin
      v.e_exc = (v.flush_cyc != 0); v.e_cause = 2; return v;
    end
    if (off % nb != 0) begin
      v.e_exc = (v.flush_cyc != 0); v.e_cause = v.ld ? 4 : 6; return v;
    end
    v.e_req = 1; v.e_we = v.st; v.e_be = 4'hF;
    if (v.st) begin
      v.e_be = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) v.e_wdata[8*i +: 8] = v.data[8*(i % nb) +: 8];
    end
    last = v.ack_dly;
`ifdef LSU_TIMEOUT_EN
    if (last > TO - 1) last = TO - 1;
`endif
    disc = (v.flush_cyc == 0) || (v.flush_cyc >= 1 && v.flush_cyc - 1 <= last);
`ifdef LSU_TIMEOUT_EN
    if (v.ack_dly >= TO) begin
      v.e_exc = !disc; v.e_cause = v.ld ? 5 : 7; return v;
    end
`endif
    if (v.ld && v.rd != 0 && !disc) begin
      x = longint'(v.rdata / (32'd1 << (8 * off)));
      if (nb < 4) x = x % (longint'(1) << (8 * nb));
      if (nb < 4 && v.f3 < 4 && x >= (longint'(1) << (8 * nb - 1))) x = x - (longint'(1) << (8 * nb));
      v.e_wb = 1; v.e_wbdata = x[31:0];
    end
    return v;
  endfunction

  task automatic sample();
    if (wb_valid) begin p_wb++; c_wbrd = wb_rd; c_wbdata = wb_data; end
    if (done) p_done++;
    if (exc_valid) begin p_exc++; c_cause = exc_cause; c_excaddr = exc_addr; end
    if (mem_req) req_cycles++;
  endtask

  task automatic recover();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_op(input vec_t v, input string nm);
    logic        saw, cwe, fin;
    logic [3:0]  cbe;
    logic [31:0] caddr, cwdata;
    int          unstable;
    p_wb = 0; p_done = 0; p_exc = 0; req_cycles = 0; unstable = 0;
    chk({nm, ".ready_in"}, {31'd0, ex_ready}, 32'd1);
    ex_valid = 1; ex_is_load = v.ld; ex_is_store = v.st; ex_funct3 = v.f3;
    ex_addr = v.addr; ex_store_data = v.data; ex_rd = v.rd; flush = (v.flush_cyc == 0);
    @(posedge clk); #1;
    ex_valid = 0; ex_is_load = 0; ex_is_store = 0; flush = 0;
    ex_addr = $urandom; ex_store_data = $urandom;
    sample();
    saw = mem_req; cwe = mem_we; cbe = mem_be; caddr = mem_addr; cwdata = mem_wdata;
    fin = !mem_req;
    for (int n = 0; n < 300 && !fin; n++) begin
      mem_ack = (n == v.ack_dly);
      mem_rdata = (n == v.ack_dly) ? v.rdata : $urandom;
      flush = (v.flush_cyc == n + 1);
      @(posedge clk); #1;
      mem_ack = 0; flush = 0;
      sample();
      if (!mem_req) fin = 1;
      else if ({mem_we, mem_be, mem_addr, mem_wdata} != {cwe, cbe, caddr, cwdata}) unstable++;
    end
    if (!fin) begin
      chk({nm, ".req_bounded"}, 32'd0, 32'd1);
      recover();
    end
    chk({nm, ".ready_out"}, {30'd0, ex_ready, busy}, 32'd2);
    @(posedge clk); #1;
    sample();
    chk({nm, ".req"}, {31'd0, saw}, {31'd0, v.e_req});
    if (v.e_req) begin
      chk({nm, ".we"}, {31'd0, cwe}, {31'd0, v.e_we});
      chk({nm, ".addr"}, caddr, {v.addr[31:2], 2'b00});
      chk({nm, ".be"}, {28'd0, cbe}, {28'd0, v.e_be});
      if (v.e_we) chk({nm, ".wdata"}, cwdata, v.e_wdata);
      chk({nm, ".stable"}, unstable, 0);
    end
    chk({nm, ".wb_cnt"}, p_wb, {31'd0, v.e_wb});
    if (v.e_wb) begin
      chk({nm, ".wb_rd"}, {27'd0, c_wbrd}, {27'd0, v.rd});
      chk({nm, ".wb_data"}, c_wbdata, v.e_wbdata);
    end
    chk({nm, ".exc_cnt"}, p_exc, {31'd0, v.e_exc});
    if (v.e_exc) begin
      chk({nm, ".cause"}, {28'd0, c_cause}, {28'd0, v.e_cause});
      chk({nm, ".exc_addr"}, c_excaddr, v.addr);
    end
    chk({nm, ".done_cnt"}, p_done, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int last;

    tbl.push_back(mk(1,0,0,32'h1003,0,32'h80ABCD12,5,3,-1, 1,0,4'hF,0, 1,32'hFFFFFF80,0,0));
    tbl.push_back(mk(0,1,1,32'h2002,32'h0000BEEF,0,0,1,-1, 1,1,4'hC,32'hBEEFBEEF, 0,0,0,0));
    tbl.push_back(mk(1,0,2,32'h3001,0,0,1,0,-1, 0,0,0,0, 0,0,1,4));
    tbl.push_back(mk(1,0,3,32'h0100,0,0,1,0,-1, 0,0,0,0, 0,0,1,2));
    tbl.push_back(mk(1,0,5,32'h0002,0,32'h12345678,7,2,2, 1,0,4'hF,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0041,32'h123456A5,0,0,0,-1, 1,1,4'h2,32'hA5A5A5A5, 0,0,0,0));
    tbl.push_back(mk(0,1,2,32'h0050,32'hDEADBEEF,0,0,1,-1, 1,1,4'hF,32'hDEADBEEF, 0,0,0,0));
    tbl.push_back(mk(1,0,1,32'h0006,0,32'h80010000,3,1,-1, 1,0,4'hF,0, 1,32'hFFFF8001,0,0));
    tbl.push_back(mk(1,0,4,32'h0001,0,32'h0000F000,4,2,-1, 1,0,4'hF,0, 1,32'h000000F0,0,0));
    tbl.push_back(mk(1,0,2,32'h0008,0,32'h12345678,0,1,-1, 1,0,4'hF,0, 0,0,0,0));
    tbl.push_back(mk(1,1,2,32'h0010,0,0,1,0,-1, 0,0,0,0, 0,0,1,2));
    tbl.push_back(mk(0,1,1,32'h0003,0,0,0,0,-1, 0,0,0,0, 0,0,1,6));
    tbl.push_back(mk(0,1,3,32'h0000,0,0,0,0,-1, 0,0,0,0, 0,0,1,2));
    tbl.push_back(mk(1,0,1,32'h0001,0,0,1,0,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,2,32'h0104,0,32'h11223344,31,0,-1, 1,0,4'hF,0, 1,32'h11223344,0,0));
    tbl.push_back(mk(0,1,2,32'h0022,0,0,0,0,-1, 0,0,0,0, 0,0,1,6));
    tbl.push_back(mk(1,0,5,32'h0002,0,32'h87654321,2,0,-1, 1,0,4'hF,0, 1,32'h00008765,0,0));
    tbl.push_back(mk(1,0,0,32'h0000,0,32'hFFFFFF7F,6,0,-1, 1,0,4'hF,0, 1,32'h0000007F,0,0));

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("reset.outs", {31'd0, mem_req | mem_we | wb_valid | done | exc_valid | busy | ex_ready}, 0);
    chk("reset.buses", mem_addr | mem_wdata | wb_data | exc_addr | {28'd0, mem_be | exc_cause}, 0);
    rst = 1'b0;
    #1;
    chk("reset.ready", {31'd0, ex_ready}, 1);
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

    // mem_ack and flush while idle are ignored
    mem_ack = 1; flush = 1; mem_rdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    mem_ack = 0; flush = 0;
    chk("idle_ack", {27'd0, busy, mem_req, wb_valid, done, exc_valid}, 0);

    // back-to-back: second op accepted in the cycle the first retires
    ex_valid = 1; ex_is_store = 1; ex_funct3 = 3'd2; ex_addr = 32'h80; ex_store_data = 32'h01020304;
    @(posedge clk); #1;
    ex_valid = 0; ex_is_store = 0; mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("b2b.first_done", {29'd0, done, ex_ready, mem_req}, 32'b110);
    ex_valid = 1; ex_is_load = 1; ex_funct3 = 3'd2; ex_addr = 32'h90; ex_rd = 5'd9;
    @(posedge clk); #1;
    ex_valid = 0; ex_is_load = 0;
    chk("b2b.second_req", {31'd0, mem_req}, 1);
    chk("b2b.second_addr", mem_addr, 32'h90);
    mem_ack = 1; mem_rdata = 32'hCAFEBABE;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("b2b.wb", {31'd0, wb_valid}, 1);
    chk("b2b.wb_data", wb_data, 32'hCAFEBABE);
    @(posedge clk); #1;

    // reset mid-transaction
    ex_valid = 1; ex_is_load = 1; ex_funct3 = 3'd2; ex_addr = 32'h40; ex_rd = 5'd1;
    @(posedge clk); #1;
    ex_valid = 0; ex_is_load = 0;
    chk("rstmid.req_before", {31'd0, mem_req}, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.async", {28'd0, mem_req, busy, ex_ready, wb_valid | done | exc_valid}, 0);
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_ack = 0; rst = 1'b0;
    p_wb = 0; p_done = 0; p_exc = 0; req_cycles = 0;
    @(posedge clk); #1;
    sample();
    chk("rstmid.no_pulse", p_wb + p_done + p_exc + req_cycles, 0);
    chk("rstmid.ready", {31'd0, ex_ready}, 1);

`ifdef LSU_TIMEOUT_EN
    v = mk(0,1,2,32'h0700,32'hCAFEF00D,0,0,20,-1, 0,0,0,0,0,0,0,0);
    run_op(model(v), "to_store");
    chk("to_store.req_cycles", req_cycles, TO);
    v = mk(0,1,2,32'h0704,32'h0BADF00D,0,0,TO-1,-1, 0,0,0,0,0,0,0,0);
    run_op(model(v), "to_ack_last");
    chk("to_ack_last.req_cycles", req_cycles, TO);
    v = mk(1,0,2,32'h0708,0,0,3,20,-1, 0,0,0,0,0,0,0,0);
    run_op(model(v), "to_load");
`endif

    // randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 9);
      v.ld = (r == 0) || (r <= 5);
      v.st = (r == 0) || (r > 5);
      v.f3 = v.st && !v.ld ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      v.addr = $urandom; v.data = $urandom; v.rdata = $urandom;
      v.rd = 5'($urandom_range(0, 31));
      v.ack_dly = $urandom_range(0, 5);
      last = v.ack_dly;
`ifdef LSU_TIMEOUT_EN
      if (last > TO - 1) last = TO - 1;
`endif
      v.flush_cyc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, last + 1) : -1;
      run_op(model(v), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the MinCPU RV32I core, directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address, together with store data and funct3, and runs one data-memory transaction over a req/ack bus.
- Aligns and extends load data, or generates byte enables and replicated write data for stores.
- Returns a registered writeback or exception pulse to the pipeline; one outstanding operation at a time.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 255, number of cycles in REQ without mem_ack before an access fault is raised (needs LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  execute stage presents a memory op.
- ex_ready  out  1  LSU can accept; equals (state==IDLE).
- ex_is_load  in  1  op is a load.
- ex_is_store  in  1  op is a store.
- ex_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- ex_addr  in  ADDR_WIDTH  effective address (ALU result).
- ex_store_data  in  DATA_WIDTH  rs2 value.
- ex_rd  in  5  destination register.
- flush  in  1  discard the result of the in-flight op.
- mem_req  out  1  bus request; held high until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  transaction complete; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  read word.
- wb_valid  out  1  one-cycle load writeback pulse.
- wb_rd  out  5  writeback register.
- wb_data  out  DATA_WIDTH  aligned, extended load data.
- done  out  1  one-cycle pulse when any op retires (load, store or exception).
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  4  2 = illegal, 4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault.
- exc_addr  out  ADDR_WIDTH  faulting ex_addr.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: every output is 0 and state is IDLE; ex_ready is 1 once rst deasserts. Reset mid-transaction drops mem_req immediately, with no wb or exc pulse.
- States: IDLE, REQ.
- Accept: accept occurs when ex_valid & ex_ready & (ex_is_load | ex_is_store). The op is latched into a request register.
- Decode checks at accept, in priority order:
  - Illegal: both load and store set, load funct3 in {3,6,7}, or store funct3 > 2. Cause 2; no bus cycle.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. Cause 4 or 6; no bus cycle.
  - In both cases exc_valid and done pulse the next cycle and state stays IDLE.
- Otherwise state goes to REQ. mem_req and the mem_* outputs are registered, asserted from the cycle after accept, and held stable until mem_ack.
- Store data and byte enables (off = addr[1:0]):
  - SB: mem_be = 4'b0001<<off; mem_wdata = {4{data[7:0]}}.
  - SH: mem_be = 4'b0011<<off; mem_wdata = {2{data[15:0]}}.
  - SW: mem_be = 4'b1111; mem_wdata = data.
  - Loads drive mem_be = 4'b1111 and mem_we = 0.
- mem_ack while in REQ:
  - mem_req drops the next cycle and state returns to IDLE.
  - For a load, wb_valid pulses the next cycle with wb_data selected from lane off: LB/LH sign-extend, LBU/LHU zero-extend.
  - wb_valid is suppressed when rd==0; done still pulses.
  - ex_ready is high in that same next cycle, so back-to-back ops issue every 2 + bus-latency cycles.
- flush while busy: the bus transaction still completes (the request is never withdrawn), but the result is discarded. No wb_valid or exc_valid for that op; done still pulses.
- flush in IDLE has no effect. flush in the same cycle as accept applies to the op being accepted.
- mem_ack outside REQ is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to REQ and increments each REQ cycle without ack. On reaching TIMEOUT_CYCLES, mem_req drops, state goes to IDLE, and exc_valid pulses with cause 5 or 7 (suppressed if flushed).
- mem_ack in the same cycle the counter reaches TIMEOUT_CYCLES wins: normal completion, no fault.
- Undefined: no counter; REQ waits indefinitely for mem_ack.

Test Plan:
- LB, addr 0x1003, rdata 0x80AB_CD12, rd 5, ack after 3 cycles -> wb_valid one cycle, wb_rd 5, wb_data 0xFFFF_FF80, done 1.
- SH, addr 0x2002, data 0x0000_BEEF -> mem_addr 0x2000, mem_be 4'b1100, mem_wdata 0xBEEF_BEEF, mem_we 1, no wb_valid.
- LW, addr 0x3001 -> no mem_req, exc_valid with cause 4 and exc_addr 0x3001 the next cycle. Load funct3 3 -> cause 2.
- LHU, addr 0x0002, flush asserted while in REQ, then ack with rdata 0x1234_5678 -> no wb_valid, done pulses, ex_ready returns high.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, a store is never acked -> mem_req drops after 4 REQ cycles with cause 7. A second run with ack exactly on cycle 4 -> no exception.
- Assert rst while mem_req is high -> mem_req is 0 without waiting for a clock edge, busy is 0, no pulses.
